// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount24 family: widths, generator FSM states
// and the weight-k mask helpers.
package popcount_pkg;

  localparam int unsigned POPCOUNT_WIDTH = 24;
  localparam int unsigned POPCOUNT_CNT_W = 5;
  localparam int unsigned POPCOUNT_IDX_W = 22;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } popgen_state_t;

  // Smallest vector of weight k: k ones packed at the bottom.
  function automatic logic [POPCOUNT_WIDTH-1:0] popcount_low_mask(
    input logic [POPCOUNT_CNT_W-1:0] k
  );
    return ~({POPCOUNT_WIDTH{1'b1}} << k);
  endfunction

  // Largest vector of weight k: k ones packed at the top.
  function automatic logic [POPCOUNT_WIDTH-1:0] popcount_top_mask(
    input logic [POPCOUNT_CNT_W-1:0] k
  );
    return ~({POPCOUNT_WIDTH{1'b1}} >> k);
  endfunction

endpackage

// File: rtl/popcount24_gosper_next.sv
// Combinational Gosper step: next larger 24-bit vector with the same popcount.
// wrap is the carry out of v + lowbit(v); it is set only for the top-packed vector.
module popcount24_gosper_next
  import popcount_pkg::*;
(
  input  logic [POPCOUNT_WIDTH-1:0] v,
  output logic [POPCOUNT_WIDTH-1:0] next,
  output logic                      wrap
);

  logic [POPCOUNT_WIDTH-1:0] c;
  logic [POPCOUNT_WIDTH:0]   r;
  logic [POPCOUNT_WIDTH:0]   diff;
  logic [POPCOUNT_WIDTH-1:0] shifted;
  logic [POPCOUNT_CNT_W-1:0] tz;

  // Trailing-zero count of v, which equals ctz(c); scanning downward keeps the lowest one.
  always_comb begin
    tz = '0;
    for (int i = POPCOUNT_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        tz = POPCOUNT_CNT_W'(i);
      end
    end
  end

  assign c       = v & (-v);
  assign r       = {1'b0, v} + {1'b0, c};
  assign diff    = r ^ {1'b0, v};
  assign shifted = POPCOUNT_WIDTH'((diff >> 2) >> tz);
  assign next    = shifted | r[POPCOUNT_WIDTH-1:0];
  assign wrap    = r[POPCOUNT_WIDTH];

endmodule

// File: rtl/popcount24_weight_gen.sv
// Constant-weight pattern generator: emits every 24-bit vector of popcount k in
// ascending order over a valid/ready handshake. Define POPCOUNT_GEN_INDEX_EN to build
// the out_index ordinal counter; otherwise out_index is tied to zero.
module popcount24_weight_gen
  import popcount_pkg::*;
#(
  parameter int unsigned WIDTH = POPCOUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [POPCOUNT_CNT_W-1:0] weight,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_vec,
  output logic [POPCOUNT_CNT_W-1:0] out_weight,
  output logic                      out_last,
  output logic                      done,
  output logic                      err,
  output logic [POPCOUNT_IDX_W-1:0] out_index
);

  localparam logic [POPCOUNT_CNT_W-1:0] MaxK = POPCOUNT_CNT_W'(POPCOUNT_WIDTH);

  popgen_state_t             state_q, state_d;
  logic [WIDTH-1:0]          vec_q, vec_d;
  logic [POPCOUNT_CNT_W-1:0] weight_q, weight_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic [WIDTH-1:0] nxt_vec;
  logic             nxt_wrap;
  logic             accept;
  logic             handshake;
  logic             final_vec;

  popcount24_gosper_next u_next (
    .v    (vec_q),
    .next (nxt_vec),
    .wrap (nxt_wrap)
  );

  assign accept    = (state_q == IDLE) && start && (weight <= MaxK);
  assign handshake = (state_q == RUN) && out_ready;
  // k = 0 has a single all-zero vector that never produces a carry.
  assign final_vec = nxt_wrap || (weight_q == '0);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    weight_d = weight_q;
    last_d   = last_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          weight_d = weight;
          vec_d    = popcount_low_mask(weight);
          last_d   = (popcount_low_mask(weight) == popcount_top_mask(weight));
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      RUN: begin
        if (handshake) begin
          if (final_vec) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            vec_d  = nxt_vec;
            last_d = (nxt_vec == popcount_top_mask(weight_q));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      weight_q <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      weight_q <= weight_d;
      last_q   <= last_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef POPCOUNT_GEN_INDEX_EN
  logic [POPCOUNT_IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
    end else if (handshake && !final_vec) begin
      idx_q <= idx_q + POPCOUNT_IDX_W'(1);
    end
  end

  assign out_index = idx_q;
`else
  assign out_index = '0;
`endif

  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == RUN);
  assign out_vec    = vec_q;
  assign out_weight = weight_q;
  assign out_last   = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/popcount24_weight_gen.md
# popcount24_weight_gen

Sequential constant-weight test-pattern generator: given a weight k (0..24), it emits every 24-bit vector containing exactly k ones, one per accepted handshake, in ascending numeric order. It is the inverse of the 24-input popcount circuits: it maps a count to the bit patterns that carry it. It drives the on-chip and FPGA error-characterisation harness (MAE/WCE/EP per weight class) of the approximate popcount24 variants. Downstream logic compares each emitted vector's approximate count against `out_weight`.

## Interface
- `WIDTH`, 24: vector width; the design is verified only at 24.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a new enumeration; sampled only in IDLE.
- `weight`  in  5  requested k; latched on accepted `start`.
- `busy`  out  1  high in RUN.
- `out_valid`  out  1  `out_vec` holds a valid vector.
- `out_ready`  in  1  consumer accepts the vector when high together with `out_valid`.
- `out_vec`  out  24  current vector.
- `out_weight`  out  5  latched k.
- `out_last`  out  1  current vector is the final one for this k.
- `done`  out  1  one-cycle pulse after the final vector is accepted.
- `err`  out  1  one-cycle pulse when `start` is given with `weight` > 24.
- `out_index`  out  22  zero-based ordinal of `out_vec` (see Configuration).

## Operation
- The FSM has two states, IDLE and RUN.
  - IDLE with `start` and `weight` <= 24: latch k, load `out_vec` = (1<<k)-1, go to RUN.
  - IDLE with `start` and `weight` > 24: pulse `err`, stay in IDLE, output nothing.
  - RUN with handshake (`out_valid` & `out_ready`) and `out_last`: go to IDLE and pulse `done`.
  - RUN with handshake and not `out_last`: load the next vector.
  - RUN without handshake: hold all outputs.
- `start` is ignored in RUN.
- Next vector (Gosper step):
  - c = v & -v
  - r = v + c, computed at 25 bits
  - next = (((r ^ v) >> 2) >> ctz(c)) | r, truncated to 24 bits
- `out_last` = r[24] for k >= 1. `out_last` = 1 for k = 0, whose single vector is 0x000000. k = 24 yields the single vector 0xFFFFFF.
- Vector count is C(24,k). The maximum is 2,704,156 at k = 12.
- `out_vec`, `out_weight` and `out_last` are registered. No combinational path from `out_ready` to any output.

## Timing
- Reset values: state IDLE, `busy` 0, `out_valid` 0, `out_vec` 0, `out_weight` 0, `out_last` 0, `done` 0, `err` 0, `out_index` 0.
- Latency:
  - `start` accepted at edge t: `out_valid` = 1 and `busy` = 1 after edge t.
  - `err` is high for the cycle after edge t.
- Throughput is one vector per cycle while `out_ready` is held high. No bubbles between vectors.
- Backpressure: while `out_valid` & !`out_ready`, all outputs remain stable.
- Final handshake at edge t: after t, `out_valid` = 0, `busy` = 0, `done` = 1 for exactly one cycle. A new `start` is accepted on the edge after t.
- `rst` mid-run: the next edge forces IDLE and all reset values. No `done` pulse.
- `rst` together with `start`: `rst` wins.

## Configuration
- `POPCOUNT_GEN_INDEX_EN` defined:
  - A 22-bit ordinal counter is built.
  - It clears on an accepted `start` and increments on each handshake.
  - `out_index` reports its value; at the final vector it equals C(24,k)-1.
- `POPCOUNT_GEN_INDEX_EN` undefined: the counter is omitted and `out_index` is tied to 0.
- All other behaviour is identical in both configurations.

## Structure
- Shared package `popcount_pkg` holds:
  - `POPCOUNT_WIDTH` = 24
  - `POPCOUNT_CNT_W` = 5
  - `POPCOUNT_IDX_W` = 22
  - enum `popgen_state_t` {IDLE, RUN}
- One combinational sub-module, `popcount24_gosper_next`:
  - inputs: v[23:0]
  - outputs: next[23:0], wrap (= r[24])
  - includes the 24-bit trailing-zero priority encoder
- The top level holds the FSM, registers and optional counter.

## Test plan
- k = 0, `out_ready` = 1: exactly one vector 0x000000 with `out_last` = 1, then a `done` pulse; `busy` is low again 2 cycles after `start`.
- k = 2, `out_ready` = 1: sequence starts 0x000003, 0x000005, 0x000006, 0x000009; 276 vectors total; the last is 0xC00000 with `out_last`; every vector has popcount 2.
- k = 24: a single vector 0xFFFFFF with `out_last`. k = 25: `err` pulses one cycle, `out_valid` stays 0, `busy` stays 0.
- k = 1 with `out_ready` low for 3 cycles at vector 0x000004: `out_vec` is held at 0x000004 and `out_index` at 2; after release the next vector is 0x000008.
- k = 12 with `POPCOUNT_GEN_INDEX_EN` defined:
  - 2,704,156 vectors, strictly ascending, with no repeats
  - final `out_index` = 2,704,155
  - final vector 0xFFF000
- `rst` asserted mid-run at k = 5: next cycle all outputs at reset values and no `done`; a fresh `start` with k = 5 restarts at 0x00001F.
